// File: rtl/rtx_pkg.sv
// Shared types and constants for the RTX pixel packer.
// BAYER4 and sat_add serve the optional RTX_PACKER_DITHER_EN stage-1 path.
package rtx_pkg;

    localparam int H_ACTIVE_DEF   = 1280;
    localparam int V_ACTIVE_DEF   = 720;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color8_t;

    // 37-bit FIFO payload: converted pixel plus its coordinates.
    typedef struct packed {
        logic [15:0] pixel;
        logic [10:0] h;
        logic [9:0]  v;
    } out_word_t;

    // Indexed [row = v[1:0]][column = h[1:0]].
    localparam logic [3:0] BAYER4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    function automatic logic [15:0] to_rgb565(input color8_t c);
        return {c.r[7:3], c.g[7:2], c.b[7:3]};
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] x, input logic [7:0] d);
        logic [8:0] sum;
        sum = {1'b0, x} + {1'b0, d};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/pixel_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible on rdata_o
// whenever empty_o is low. DEPTH must be a power of two.
module pixel_fifo_fwft #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH[AW:0]);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; validity is tracked by count_q, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/rtx_pixel_packer.sv
// Range-checks tracer pixels, converts 8:8:8 colour to RGB565 and buffers them in an FWFT FIFO.
// Define RTX_PACKER_DITHER_EN to add 4x4 ordered Bayer dither ahead of truncation.
module rtx_pixel_packer
    import rtx_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_color,
    input  logic [10:0] in_h,
    input  logic [9:0]  in_v,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pixel,
    output logic [10:0] out_h,
    output logic [9:0]  out_v,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic [15:0] drop_count
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = FIFO_DEPTH[CW:0];
    localparam logic [10:0] H_LIM     = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM     = 10'(V_ACTIVE);
    localparam logic [10:0] H_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE - 1);

    color8_t       in_c;
    logic [15:0]   conv_pixel;
    logic          in_fire, in_range, pop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          fifo_full, fifo_empty;
    out_word_t     head, shown;

    logic          s1_valid_q, s1_valid_d;
    out_word_t     s1_word_q, s1_word_d;
    out_word_t     hold_q, hold_d;
    logic [15:0]   drop_count_q, drop_count_d;
    logic [7:0]    frame_count_q, frame_count_d;
    logic          frame_done_q, frame_done_d;

    assign in_c = in_color;

`ifdef RTX_PACKER_DITHER_EN
    logic [3:0] thresh;
    color8_t    dith;

    assign thresh = BAYER4[in_v[1:0]][in_h[1:0]];
    assign dith.r = sat_add(in_c.r, {4'd0, thresh >> 1});
    assign dith.g = sat_add(in_c.g, {4'd0, thresh >> 2});
    assign dith.b = sat_add(in_c.b, {4'd0, thresh >> 1});
    assign conv_pixel = to_rgb565(dith);
`else
    assign conv_pixel = to_rgb565(in_c);
`endif

    // The pixel sitting in stage 1 already owns a FIFO slot, so a push can never overflow.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_q};
    assign in_ready  = !rst && (occupancy < DEPTH_LIM);
    assign in_fire   = in_valid && in_ready;
    assign in_range  = (in_h < H_LIM) && (in_v < V_LIM);
    assign pop       = !fifo_empty && out_ready;

    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    always_comb begin
        s1_valid_d = in_fire && in_range;
        s1_word_d  = s1_word_q;
        if (in_fire && in_range) begin
            s1_word_d = '{pixel: conv_pixel, h: in_h, v: in_v};
        end

        drop_count_d = drop_count_q;
        if (in_fire && !in_range && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end

        hold_d        = pop ? head : hold_q;
        frame_done_d  = pop && (head.h == H_LAST) && (head.v == V_LAST);
        frame_count_d = frame_done_d ? frame_count_q + 8'd1 : frame_count_q;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_word_q     <= '0;
            hold_q        <= '0;
            drop_count_q  <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_word_q     <= s1_word_d;
            hold_q        <= hold_d;
            drop_count_q  <= drop_count_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
        end
    end

    pixel_fifo_fwft #(
        .WIDTH ($bits(out_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s1_valid_q),
        .wdata_i (s1_word_q),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(s1_valid_q && fifo_full))
                else $error("rtx_pixel_packer: stage-1 push found the FIFO full");
        end
    end

    // While empty the outputs keep showing the last popped entry.
    assign shown       = fifo_empty ? hold_q : head;
    assign out_valid   = !fifo_empty;
    assign out_pixel   = shown.pixel;
    assign out_h       = shown.h;
    assign out_v       = shown.v;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_rtx_pixel_packer.sv
// Directed self-checking bench for rtx_pixel_packer; expectations switch with RTX_PACKER_DITHER_EN.
module tb_rtx_pixel_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_color;
    logic [10:0] in_h;
    logic [9:0]  in_v;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pixel;
    logic [10:0] out_h;
    logic [9:0]  out_v;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rtx_pixel_packer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_color    (in_color),
        .in_h        (in_h),
        .in_v        (in_v),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pixel   (out_pixel),
        .out_h       (out_h),
        .out_v       (out_v),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [23:0] c, input logic [10:0] h, input logic [9:0] vv);
        in_valid = v;
        in_color = c;
        in_h     = h;
        in_v     = vv;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           acc;
        int           pulses;
        int           stale;
        logic [15:0]  exp_pix;

        // Reset state
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 24'h0, 11'd0, 10'd0);
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pixel", out_pixel, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_drop_count", drop_count, 0);
        rst = 1'b0;
        tick();
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);

        // Single pixel, two-cycle latency
        drive(1'b1, 24'hFF8040, 11'd5, 10'd3);
        tick();
        drive(1'b0, 24'h0, 11'd0, 10'd0);
        check("t1_latency_n1", out_valid, 0);
        tick();
        check("t1_out_valid", out_valid, 1);
        check("t1_out_pixel", out_pixel, 16'hFC08);
        check("t1_out_h", out_h, 5);
        check("t1_out_v", out_v, 3);
        tick();
        check("t1_empty_after_pop", out_valid, 0);
        check("t1_hold_pixel", out_pixel, 16'hFC08);

        // Out-of-range drops
        drive(1'b1, 24'h123456, 11'd1280, 10'd0);
        tick();
        drive(1'b0, 24'h0, 11'd0, 10'd0);
        check("t2_drop_h", drop_count, 1);
        tick();
        check("t2_no_out_h", out_valid, 0);
        drive(1'b1, 24'h123456, 11'd0, 10'd720);
        tick();
        drive(1'b0, 24'h0, 11'd0, 10'd0);
        check("t2_drop_v", drop_count, 2);
        tick();
        check("t2_no_out_v", out_valid, 0);

        // Back-pressure: 20 offered, 16 accepted, drained in order
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, {8'(i * 8), 8'(i * 4), 8'(i * 8)}, 11'(i), 10'd0);
            if (in_ready) acc++;
            tick();
        end
        drive(1'b0, 24'h0, 11'd0, 10'd0);
        tick();
        tick();
        check("t3_accepted", acc, 16);
        check("t3_in_ready_full", in_ready, 0);
        check("t3_valid_full", out_valid, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_pix = {5'(k), 6'(k), 5'(k)};
            check($sformatf("t3_drain_valid_%0d", k), out_valid, 1);
            check($sformatf("t3_drain_h_%0d", k), out_h, k);
            check($sformatf("t3_drain_pix_%0d", k), out_pixel, exp_pix);
            tick();
        end
        check("t3_drained", out_valid, 0);
        check("t3_in_ready_back", in_ready, 1);

        // Frame end: one frame
        drive(1'b1, 24'h808080, 11'd1279, 10'd719);
        tick();
        drive(1'b0, 24'h0, 11'd0, 10'd0);
        check("t4_no_early_done", frame_done, 0);
        tick();
        check("t4_head_h", out_h, 1279);
        check("t4_head_v", out_v, 719);
        check("t4_done_before_pop", frame_done, 0);
        tick();
        check("t4_frame_done", frame_done, 1);
        check("t4_frame_count", frame_count, 1);
        tick();
        check("t4_done_single", frame_done, 0);
        check("t4_count_hold", frame_count, 1);

        // Reset mid-stream with 5 buffered pixels
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 24'hABCDEF, 11'(100 + i), 10'd7);
            tick();
        end
        drive(1'b0, 24'h0, 11'd0, 10'd0);
        tick();
        tick();
        check("t5_buffered_valid", out_valid, 1);
        check("t5_buffered_h", out_h, 100);
        rst = 1'b1;
        tick();
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_in_ready", in_ready, 0);
        check("t5_rst_frame_count", frame_count, 0);
        check("t5_rst_drop_count", drop_count, 0);
        check("t5_rst_pixel", out_pixel, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) stale++;
        end
        check("t5_no_stale", stale, 0);
        drive(1'b1, 24'h123456, 11'd9, 10'd9);
        tick();
        drive(1'b0, 24'h0, 11'd0, 10'd0);
        tick();
`ifdef RTX_PACKER_DITHER_EN
        exp_pix = 16'h11AB;
`else
        exp_pix = 16'h11AA;
`endif
        check("t5_fresh_valid", out_valid, 1);
        check("t5_fresh_h", out_h, 9);
        check("t5_fresh_pixel", out_pixel, exp_pix);
        tick();

        // 256 frames back-to-back: frame_count wraps to 0
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 24'h0, 11'd1279, 10'd719);
            check($sformatf("t4w_in_ready_%0d", i), in_ready, 1);
            tick();
            if (frame_done) pulses++;
        end
        drive(1'b0, 24'h0, 11'd0, 10'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (frame_done) pulses++;
        end
        check("t4w_pulses", pulses, 256);
        check("t4w_frame_count_wrap", frame_count, 0);

        // Dither / truncation corner colours, back-to-back
        drive(1'b1, 24'h040204, 11'd1, 10'd0);
        tick();
        drive(1'b1, 24'hFFFFFF, 11'd1, 10'd0);
        tick();
        drive(1'b0, 24'h0, 11'd0, 10'd0);
`ifdef RTX_PACKER_DITHER_EN
        exp_pix = 16'h0821;
`else
        exp_pix = 16'h0000;
`endif
        check("t6_small_valid", out_valid, 1);
        check("t6_small_pixel", out_pixel, exp_pix);
        tick();
        check("t6_sat_valid", out_valid, 1);
        check("t6_sat_pixel", out_pixel, 16'hFFFF);
        tick();
        check("t6_empty", out_valid, 0);
        check("t6_drop_count", drop_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
